// File: rtl/proc_defs.sv
// Shared processor definitions: multiply/divide opcode fields, latency defaults
// and the multdiv controller state encoding.
package proc_defs;

  localparam logic [4:0] OPC_ALU  = 5'b00000;
  localparam logic [4:0] ALU_MULT = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam int DEF_MULT_CYCLES = 32;
  localparam int DEF_DIV_CYCLES  = 33;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_counter.sv
// Saturating cycle counter for the multdiv controller; holds at limit-1.
module md_counter #(
  parameter int CW = 6
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q < (limit - CW'(1)))) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/multdiv_ctrl.sv
// Multiply/divide issue controller: starts the unit, stalls the front end
// while it runs, and hands the result to X/M for one cycle.
module multdiv_ctrl
  import proc_defs::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CW          = 6
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [31:0]   dx_ir,
  input  logic          flush,
  input  logic          md_result_ready,
  input  logic          md_exception_in,
  output logic          stall,
  output logic          md_ctrl_mult,
  output logic          md_ctrl_div,
  output logic [CW-1:0] md_count,
  output logic          md_wb_valid,
  output logic          md_exception,
  output logic [4:0]    md_rd,
  output logic          md_is_div
);

  md_state_e   state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic        is_div_q, is_div_d;
  logic        exc_q, exc_d;
  logic        cnt_clear, cnt_en;
  logic [CW-1:0] limit;
  logic        at_last;
  logic        dec_md, dec_div;
  logic        unused_ir;

  assign dec_div   = (dx_ir[6:2] == ALU_DIV);
  assign dec_md    = (dx_ir[31:27] == OPC_ALU) &&
                     ((dx_ir[6:2] == ALU_MULT) || dec_div);
  assign unused_ir = ^{dx_ir[21:7], dx_ir[1:0]};

  assign limit   = is_div_q ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
  assign at_last = (md_count == (limit - CW'(1)));

  md_counter #(.CW(CW)) u_md_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .limit  (limit),
    .count  (md_count)
  );

  always_comb begin
    state_d      = state_q;
    rd_d         = rd_q;
    is_div_d     = is_div_q;
    exc_d        = exc_q;
    cnt_clear    = 1'b0;
    cnt_en       = 1'b0;
    stall        = 1'b0;
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    md_wb_valid  = 1'b0;
    md_exception = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (dec_md && !flush) begin
          md_ctrl_mult = !dec_div;
          md_ctrl_div  = dec_div;
          stall        = 1'b1;
          rd_d         = dx_ir[26:22];
          is_div_d     = dec_div;
          cnt_clear    = 1'b1;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_en = 1'b1;
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          stall = 1'b1;
          if (md_result_ready || at_last) begin
            // A timeout with no ready result is reported as an exception.
            exc_d   = (md_result_ready & md_exception_in) | ~md_result_ready;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        md_wb_valid  = 1'b1;
        md_exception = exc_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Decode-driven outputs stay quiet while reset is held.
    if (reset) begin
      stall        = 1'b0;
      md_ctrl_mult = 1'b0;
      md_ctrl_div  = 1'b0;
      md_wb_valid  = 1'b0;
      md_exception = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rd_q     <= '0;
      is_div_q <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      is_div_q <= is_div_d;
      exc_q    <= exc_d;
    end
  end

  assign md_rd     = rd_q;
  assign md_is_div = is_div_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl with hand-computed expected values.
module tb_multdiv_ctrl;

  localparam int CW = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic [31:0]   dx_ir;
  logic          flush;
  logic          md_result_ready;
  logic          md_exception_in;
  logic          stall;
  logic          md_ctrl_mult;
  logic          md_ctrl_div;
  logic [CW-1:0] md_count;
  logic          md_wb_valid;
  logic          md_exception;
  logic [4:0]    md_rd;
  logic          md_is_div;

  int checks   = 0;
  int failures = 0;

  multdiv_ctrl #(.MULT_CYCLES(32), .DIV_CYCLES(33), .CW(CW)) dut (
    .clock           (clock),
    .reset           (reset),
    .dx_ir           (dx_ir),
    .flush           (flush),
    .md_result_ready (md_result_ready),
    .md_exception_in (md_exception_in),
    .stall           (stall),
    .md_ctrl_mult    (md_ctrl_mult),
    .md_ctrl_div     (md_ctrl_div),
    .md_count        (md_count),
    .md_wb_valid     (md_wb_valid),
    .md_exception    (md_exception),
    .md_rd           (md_rd),
    .md_is_div       (md_is_div)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] md_ir(input logic [4:0] rd, input logic is_div);
    return {5'b00000, rd, 15'h1234, (is_div ? 5'b00111 : 5'b00110), 2'b00};
  endfunction

  localparam logic [31:0] ADD_IR = {5'b00000, 5'd8, 15'h0421, 5'b00000, 2'b00};

  // Advance to the next falling edge, apply inputs, then settle.
  task automatic cyc(input logic [31:0] ir, input logic fl, input logic rdy, input logic exi);
    @(negedge clock);
    dx_ir = ir; flush = fl; md_result_ready = rdy; md_exception_in = exi;
    #1;
  endtask

  initial begin
    reset = 1'b1; dx_ir = '0; flush = 1'b0;
    md_result_ready = 1'b0; md_exception_in = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_count", md_count, 0);
    chk("rst_wb", md_wb_valid, 0);
    chk("rst_rd", md_rd, 0);
    @(negedge clock); reset = 1'b0;

    // Multiply r3, result ready at cycle 5.
    cyc(md_ir(5'd3, 1'b0), 0, 0, 0);
    chk("A_c0_mult", md_ctrl_mult, 1);
    chk("A_c0_div", md_ctrl_div, 0);
    chk("A_c0_stall", stall, 1);
    for (int c = 1; c <= 5; c++) begin
      cyc(md_ir(5'd3, 1'b0), 0, (c == 5), 0);
      chk("A_run_stall", stall, 1);
      chk("A_run_nostart", md_ctrl_mult, 0);
      chk("A_run_count", md_count, c - 1);
      chk("A_run_wb", md_wb_valid, 0);
    end
    cyc(md_ir(5'd3, 1'b0), 0, 0, 0);
    chk("A_wb", md_wb_valid, 1);
    chk("A_exc", md_exception, 0);
    chk("A_stall", stall, 0);
    chk("A_rd", md_rd, 3);
    chk("A_isdiv", md_is_div, 0);
    chk("A_done_nostart", md_ctrl_mult, 0);
    cyc(ADD_IR, 0, 0, 0);
    chk("A_idle_wb", md_wb_valid, 0);
    chk("A_idle_stall", stall, 0);

    // Divide r7, ready never arrives: timeout at count 32.
    cyc(md_ir(5'd7, 1'b1), 0, 0, 0);
    chk("B_c0_div", md_ctrl_div, 1);
    chk("B_c0_mult", md_ctrl_mult, 0);
    for (int c = 1; c <= 33; c++) begin
      cyc(md_ir(5'd7, 1'b1), 0, 0, 0);
      chk("B_run_count", md_count, c - 1);
      chk("B_run_stall", stall, 1);
      chk("B_run_wb", md_wb_valid, 0);
    end
    cyc(md_ir(5'd7, 1'b1), 0, 0, 0);
    chk("B_wb", md_wb_valid, 1);
    chk("B_exc", md_exception, 1);
    chk("B_count_sat", md_count, 32);
    chk("B_isdiv", md_is_div, 1);
    chk("B_rd", md_rd, 7);
    chk("B_done_nostart", md_ctrl_div, 0);
    cyc(ADD_IR, 0, 0, 0);
    chk("B_idle_exc", md_exception, 0);

    // Divide r9, ready at count 10 with divide-by-zero.
    cyc(md_ir(5'd9, 1'b1), 0, 0, 0);
    for (int c = 1; c <= 11; c++) begin
      cyc(md_ir(5'd9, 1'b1), 0, (c == 11), (c == 11));
      chk("C_run_count", md_count, c - 1);
    end
    cyc(md_ir(5'd9, 1'b1), 0, 0, 0);
    chk("C_wb", md_wb_valid, 1);
    chk("C_exc", md_exception, 1);
    chk("C_isdiv", md_is_div, 1);
    chk("C_rd", md_rd, 9);
    chk("C_done_nostart", md_ctrl_div, 0);

    // Flush in IDLE suppresses the start.
    cyc(md_ir(5'd4, 1'b0), 1, 0, 0);
    chk("D_idleflush_mult", md_ctrl_mult, 0);
    chk("D_idleflush_stall", stall, 0);
    // Multiply r4, flushed at count 4.
    cyc(md_ir(5'd4, 1'b0), 0, 0, 0);
    chk("D_c0_mult", md_ctrl_mult, 1);
    for (int c = 1; c <= 4; c++) cyc(md_ir(5'd4, 1'b0), 0, 0, 0);
    cyc(md_ir(5'd4, 1'b0), 1, 0, 0);
    chk("D_flush_count", md_count, 4);
    chk("D_flush_stall", stall, 0);
    cyc(ADD_IR, 0, 0, 0);
    chk("D_after_stall", stall, 0);
    chk("D_after_wb", md_wb_valid, 0);
    cyc(ADD_IR, 0, 0, 0);
    chk("D_after2_wb", md_wb_valid, 0);

    // Flush and ready together: flush wins.
    cyc(md_ir(5'd5, 1'b0), 0, 0, 0);
    cyc(md_ir(5'd5, 1'b0), 0, 0, 0);
    cyc(md_ir(5'd5, 1'b0), 1, 1, 0);
    chk("E_flushrdy_stall", stall, 0);
    cyc(ADD_IR, 0, 0, 0);
    chk("E_flushrdy_wb", md_wb_valid, 0);

    // Back-to-back multiplies r1 then r2.
    cyc(md_ir(5'd1, 1'b0), 0, 0, 0);
    chk("F_start1", md_ctrl_mult, 1);
    cyc(md_ir(5'd1, 1'b0), 0, 0, 0);
    cyc(md_ir(5'd1, 1'b0), 0, 1, 0);
    cyc(md_ir(5'd1, 1'b0), 0, 0, 0);
    chk("F_wb1", md_wb_valid, 1);
    chk("F_rd1", md_rd, 1);
    chk("F_done_nostart", md_ctrl_mult, 0);
    cyc(md_ir(5'd2, 1'b0), 0, 0, 0);
    chk("F_start2", md_ctrl_mult, 1);
    chk("F_start2_stall", stall, 1);
    chk("F_start2_wb", md_wb_valid, 0);
    cyc(md_ir(5'd2, 1'b0), 0, 1, 0);
    chk("F_run2_count", md_count, 0);
    cyc(md_ir(5'd2, 1'b0), 0, 0, 0);
    chk("F_wb2", md_wb_valid, 1);
    chk("F_rd2", md_rd, 2);

    // Asynchronous reset during RUN.
    cyc(ADD_IR, 0, 0, 0);
    cyc(md_ir(5'd6, 1'b0), 0, 0, 0);
    for (int c = 1; c <= 3; c++) cyc(md_ir(5'd6, 1'b0), 0, 0, 0);
    chk("G_pre_stall", stall, 1);
    chk("G_pre_count", md_count, 2);
    #2 reset = 1'b1;
    #1;
    chk("G_rst_stall", stall, 0);
    chk("G_rst_count", md_count, 0);
    chk("G_rst_rd", md_rd, 0);
    chk("G_rst_mult", md_ctrl_mult, 0);
    @(negedge clock);
    dx_ir = ADD_IR; reset = 1'b0;
    #1;
    chk("G_post_stall", stall, 0);
    for (int c = 0; c < 3; c++) begin
      cyc(ADD_IR, 0, 1, 0);
      chk("G_post_wb", md_wb_valid, 0);
    end
    cyc(md_ir(5'd2, 1'b0), 0, 0, 0);
    chk("G_post_start", md_ctrl_mult, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 32, worst-case multiply latency in cycles after start.
REQ-002 Parameter DIV_CYCLES, default 33, worst-case divide latency in cycles after start.
REQ-003 Parameter CW, default 6, width of md_count; it SHALL hold max(MULT_CYCLES, DIV_CYCLES).
REQ-004 clock  in  1  single system clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 dx_ir  in  32  instruction currently held in the D/X latch.
REQ-007 flush  in  1  squashes the D/X instruction (taken branch or jump).
REQ-008 md_result_ready  in  1  unit result valid; may arrive before the latency limit.
REQ-009 md_exception_in  in  1  unit error flag (divide by zero); valid only with md_result_ready.
REQ-010 stall  out  1  freezes PC, F/D and D/X latches.
REQ-011 md_ctrl_mult  out  1  one-cycle start pulse to the multiplier.
REQ-012 md_ctrl_div  out  1  one-cycle start pulse to the divider.
REQ-013 md_count  out  CW  cycles elapsed since start.
REQ-014 md_wb_valid  out  1  one-cycle pulse: the result enters X/M this cycle.
REQ-015 md_exception  out  1  error flag; asserted only together with md_wb_valid.
REQ-016 md_rd  out  5  latched destination register of the active operation.
REQ-017 md_is_div  out  1  the latched operation is a divide.

Function
REQ-018 Decode: is_md SHALL be true when dx_ir[31:27]==00000 and dx_ir[6:2] is 00110 (mult) or 00111 (div).
REQ-019 States: IDLE, RUN, DONE; each state is held in a register.
REQ-020 IDLE with is_md and no flush: pulse md_ctrl_mult or md_ctrl_div, assert stall combinationally, latch rd=dx_ir[26:22] and is_div, clear count, go to RUN.
REQ-021 IDLE with flush, or with no is_md: no start pulse, stall=0, remain in IDLE.
REQ-022 RUN: stall=1 and md_count increments by 1 each cycle.
REQ-023 md_count SHALL saturate at limit-1, where limit is DIV_CYCLES for a divide and MULT_CYCLES otherwise.
REQ-024 RUN: on md_result_ready, or when md_count==limit-1, go to DONE.
REQ-025 On the RUN->DONE edge, latch exc = (md_result_ready & md_exception_in) | (~md_result_ready). A timeout without a ready result counts as an exception.
REQ-026 DONE: stall=0, md_wb_valid=1, md_exception=exc, then go unconditionally to IDLE.
REQ-027 DONE SHALL ignore is_md, so the completing instruction is not restarted.
REQ-028 A new multiply or divide arriving the cycle after DONE SHALL start normally (back-to-back issue, no dead cycle beyond DONE).
REQ-029 flush during RUN: abort to IDLE next edge, stall=0 on that cycle, no md_wb_valid.
REQ-030 flush and md_result_ready in the same cycle: flush wins.
REQ-031 Start pulses are never asserted outside IDLE, and at most one is asserted per operation.

Reset
REQ-032 reset SHALL asynchronously force IDLE, clear md_count, md_rd, md_is_div and exc, and drive all outputs to 0.
REQ-033 Reset mid-RUN SHALL abort without md_wb_valid, and the first post-reset cycle behaves as IDLE.

Structure
REQ-034 Opcode/ALU-op constants, state encodings, and MULT_CYCLES/DIV_CYCLES defaults SHALL live in the shared processor definitions package (proc_defs).
REQ-035 The saturating cycle counter SHALL be one sub-module, md_counter (clear, enable, limit, count).
REQ-036 The block is state machine plus latches only; it contains no arithmetic datapath.

Verification
REQ-037 mult r3 in D/X, ready at cycle 5 -> ctrl_mult pulse at cycle 0, stall cycles 0-5, wb_valid at cycle 6, md_rd=3, md_exception=0.
REQ-038 div, ready never asserted -> count saturates at 32, DONE on the next edge, wb_valid=1, md_exception=1.
REQ-039 div, ready at count 10 with md_exception_in=1 -> wb_valid=1, md_exception=1, md_is_div=1.
REQ-040 mult, then flush at count 4 -> IDLE next cycle, no wb_valid, stall=0; a following add is not stalled.
REQ-041 Two back-to-back mults (r1, r2) -> two start pulses, two wb_valid pulses with md_rd 1 then 2, no double start in DONE.
REQ-042 reset asserted mid-RUN, asynchronous to the clock -> outputs 0 immediately, no wb_valid after release.
